// File: rtl/dual_issue_operand_read.sv
// Operand read stage for a dual-issue pipeline: resolves four sources from the
// register file or same-cycle writebacks, tracks pending writes, registers bundles for execute.
module dual_issue_operand_read #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rt1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rt2,
  input  logic [AW-1:0] dest1,
  input  logic [AW-1:0] dest2,
  input  logic          destWr1,
  input  logic          destWr2,
  output logic [AW-1:0] raddr0,
  output logic [AW-1:0] raddr1,
  output logic [AW-1:0] raddr2,
  output logic [AW-1:0] raddr3,
  input  logic [DW-1:0] rdata0,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic [DW-1:0] rdata3,
  input  logic          regWrite1,
  input  logic          regWrite2,
  input  logic [AW-1:0] wbAddr1,
  input  logic [AW-1:0] wbAddr2,
  input  logic [DW-1:0] writeData1,
  input  logic [DW-1:0] writeData2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] opA1,
  output logic [DW-1:0] opB1,
  output logic [DW-1:0] opA2,
  output logic [DW-1:0] opB2,
  output logic [AW-1:0] outDest1,
  output logic [AW-1:0] outDest2,
  output logic          outDestWr1,
  output logic          outDestWr2
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   opA1_q, opB1_q, opA2_q, opB2_q;
  logic [DW-1:0]   opA1_d, opB1_d, opA2_d, opB2_d;
  logic [AW-1:0]   dest1_q, dest2_q, dest1_d, dest2_d;
  logic            destWr1_q, destWr2_q, destWr1_d, destWr2_d;
  logic [DW-1:0]   fwdA1_c, fwdB1_c, fwdA2_c, fwdB2_c;
  logic            hazard_c, accept_c;

  function automatic logic wb_hit(input logic [AW-1:0] a);
    return (regWrite1 && (wbAddr1 == a)) || (regWrite2 && (wbAddr2 == a));
  endfunction

  // Port 2 wins over port 1, matching the register file's write priority.
  function automatic logic [DW-1:0] resolve(input logic [AW-1:0] s, input logic [DW-1:0] rd);
    if (s == '0)                          return '0;
    else if (regWrite2 && (wbAddr2 == s)) return writeData2;
    else if (regWrite1 && (wbAddr1 == s)) return writeData1;
    else                                  return rd;
  endfunction

  function automatic logic src_stall(input logic [AW-1:0] s);
    return (s != '0) && busy_q[s] && !wb_hit(s);
  endfunction

  function automatic logic dst_stall(input logic wr, input logic [AW-1:0] d);
    return wr && (d != '0) && busy_q[d] && !wb_hit(d);
  endfunction

  assign raddr0 = rs1;
  assign raddr1 = rt1;
  assign raddr2 = rs2;
  assign raddr3 = rt2;

  // Source resolution and hazard detection against pre-pair state.
  always_comb begin
    fwdA1_c  = resolve(rs1, rdata0);
    fwdB1_c  = resolve(rt1, rdata1);
    fwdA2_c  = resolve(rs2, rdata2);
    fwdB2_c  = resolve(rt2, rdata3);
    hazard_c = src_stall(rs1) || src_stall(rt1) || src_stall(rs2) || src_stall(rt2) ||
               dst_stall(destWr1, dest1) || dst_stall(destWr2, dest2);
  end

  assign in_ready = !hazard_c && (!out_valid_q || out_ready);
  assign accept_c = in_valid && in_ready;

  // Scoreboard: writebacks clear first, accepted destinations set afterwards.
  always_comb begin
    busy_d = busy_q;
    if (regWrite1) busy_d[wbAddr1] = 1'b0;
    if (regWrite2) busy_d[wbAddr2] = 1'b0;
    if (accept_c && destWr1) busy_d[dest1] = 1'b1;
    if (accept_c && destWr2) busy_d[dest2] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Output bundle: capture on accept, otherwise hold until consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    opA1_d      = opA1_q;
    opB1_d      = opB1_q;
    opA2_d      = opA2_q;
    opB2_d      = opB2_q;
    dest1_d     = dest1_q;
    dest2_d     = dest2_q;
    destWr1_d   = destWr1_q;
    destWr2_d   = destWr2_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      opA1_d      = fwdA1_c;
      opB1_d      = fwdB1_c;
      opA2_d      = fwdA2_c;
      opB2_d      = fwdB2_c;
      dest1_d     = dest1;
      dest2_d     = dest2;
      destWr1_d   = destWr1;
      destWr2_d   = destWr2;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      opA1_q      <= '0;
      opB1_q      <= '0;
      opA2_q      <= '0;
      opB2_q      <= '0;
      dest1_q     <= '0;
      dest2_q     <= '0;
      destWr1_q   <= 1'b0;
      destWr2_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      opA1_q      <= opA1_d;
      opB1_q      <= opB1_d;
      opA2_q      <= opA2_d;
      opB2_q      <= opB2_d;
      dest1_q     <= dest1_d;
      dest2_q     <= dest2_d;
      destWr1_q   <= destWr1_d;
      destWr2_q   <= destWr2_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign opA1       = opA1_q;
  assign opB1       = opB1_q;
  assign opA2       = opA2_q;
  assign opB2       = opB2_q;
  assign outDest1   = dest1_q;
  assign outDest2   = dest2_q;
  assign outDestWr1 = destWr1_q;
  assign outDestWr2 = destWr2_q;

endmodule
